// File: rtl/dummy_accelerator_pkg.sv
// Shared types and constants for the dummy accelerator dispatcher and its reorder buffer.
// Reorder-buffer entries are sized for the system data width DATA_WIDTH.
package dummy_accelerator_pkg;

    localparam int RD_W       = 5;
    localparam int DATA_WIDTH = 32;

    function automatic int tag_width(input int num_tags);
        return (num_tags > 1) ? $clog2(num_tags) : 1;
    endfunction

    typedef struct packed {
        logic [RD_W-1:0]       rd;
        logic [DATA_WIDTH-1:0] result;
        logic                  done;
    } rob_entry_t;

endpackage

// File: rtl/dummy_accelerator_rob.sv
// Reorder buffer: tag allocation, out-of-order result capture and in-order commit port.
module dummy_accelerator_rob
    import dummy_accelerator_pkg::*;
#(
    parameter int NUM_TAGS = 4,
    parameter int TAG_W    = tag_width(NUM_TAGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  alloc_i,
    input  logic [RD_W-1:0]       alloc_rd_i,
    input  logic                  res_valid_i,
    input  logic [TAG_W-1:0]      res_tag_i,
    input  logic [DATA_WIDTH-1:0] res_data_i,
    input  logic                  commit_ready_i,
    output logic [TAG_W-1:0]      head_o,
    output logic [TAG_W:0]        count_o,
    output logic                  res_hit_o,
    output logic                  commit_valid_o,
    output logic [RD_W-1:0]       commit_rd_o,
    output logic [DATA_WIDTH-1:0] commit_result_o
);

    rob_entry_t       rob_q [NUM_TAGS];
    rob_entry_t       rob_d [NUM_TAGS];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic [TAG_W-1:0] res_offset;
    logic             commit;

    assign head_o  = head_q;
    assign count_o = count_q;

    always_comb begin
        // Distance from the oldest entry decides whether a tag is outstanding, so a full buffer accepts every tag.
        res_offset      = res_tag_i - tail_q;
        res_hit_o       = (count_q != '0) && ({1'b0, res_offset} < count_q);
        commit_valid_o  = (count_q != '0) && rob_q[tail_q].done;
        commit_rd_o     = rob_q[tail_q].rd;
        commit_result_o = rob_q[tail_q].result;
        commit          = commit_valid_o && commit_ready_i;

        rob_d   = rob_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                rob_d[i].done = 1'b0;
            end
        end else begin
            if (commit) begin
                rob_d[tail_q].done = 1'b0;
                tail_d             = tail_q + 1'b1;
            end
            if (alloc_i) begin
                rob_d[head_q].rd   = alloc_rd_i;
                rob_d[head_q].done = 1'b0;
                head_d             = head_q + 1'b1;
            end
            if (res_valid_i && res_hit_o) begin
                rob_d[res_tag_i].result = res_data_i;
                rob_d[res_tag_i].done   = 1'b1;
            end
            case ({alloc_i, commit})
                2'b10:   count_d = count_q + (TAG_W+1)'(1);
                2'b01:   count_d = count_q - (TAG_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                rob_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rob_q   <= rob_d;
        end
    end

endmodule

// File: rtl/dummy_accelerator_dispatcher.sv
// Dispatcher: issues tagged requests to the accelerator and writes results back in issue order.
module dummy_accelerator_dispatcher
    import dummy_accelerator_pkg::*;
#(
    parameter int  WIDTH          = 32,
    parameter int  IMM_WIDTH      = 11,
    parameter int  NUM_TAGS       = 4,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int TAG_W          = tag_width(NUM_TAGS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [WIDTH-1:0]     req_rs1_i,
    input  logic [IMM_WIDTH-1:0] req_imm_i,
    input  logic [RD_W-1:0]      req_rd_i,
    output logic                 acc_valid_o,
    input  logic                 acc_ready_i,
    output logic [WIDTH-1:0]     acc_rs1_o,
    output logic [IMM_WIDTH-1:0] acc_imm_o,
    output logic [TAG_W-1:0]     acc_tag_o,
    input  logic                 acc_res_valid_i,
    output logic                 acc_res_ready_o,
    input  logic [WIDTH-1:0]     acc_result_i,
    input  logic [TAG_W-1:0]     acc_tag_i,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [WIDTH-1:0]     wb_result_o,
    output logic [RD_W-1:0]      wb_rd_o,
    output logic                 busy_o,
    output logic                 timeout_o,
    output logic                 err_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic                 acc_valid_q, acc_valid_d;
    logic [WIDTH-1:0]     acc_rs1_q, acc_rs1_d;
    logic [IMM_WIDTH-1:0] acc_imm_q, acc_imm_d;
    logic [TAG_W-1:0]     acc_tag_q, acc_tag_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 commit;
    logic                 res_hit;
    logic [TAG_W-1:0]     head;
    logic [TAG_W:0]       count;

    assign req_ready_o     = (count < (TAG_W+1)'(NUM_TAGS)) && (!acc_valid_q || acc_ready_i);
    assign accept          = req_valid_i && req_ready_o && !flush_i;
    assign commit          = wb_valid_o && wb_ready_i;
    assign acc_valid_o     = acc_valid_q;
    assign acc_rs1_o       = acc_rs1_q;
    assign acc_imm_o       = acc_imm_q;
    assign acc_tag_o       = acc_tag_q;
    assign acc_res_ready_o = 1'b1;
    assign busy_o          = (count != '0) || acc_valid_q;
    assign timeout_o       = timeout_q;
    assign err_o           = err_q;

    dummy_accelerator_rob #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) u_rob (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .alloc_i         (accept),
        .alloc_rd_i      (req_rd_i),
        .res_valid_i     (acc_res_valid_i),
        .res_tag_i       (acc_tag_i),
        .res_data_i      (acc_result_i),
        .commit_ready_i  (wb_ready_i),
        .head_o          (head),
        .count_o         (count),
        .res_hit_o       (res_hit),
        .commit_valid_o  (wb_valid_o),
        .commit_rd_o     (wb_rd_o),
        .commit_result_o (wb_result_o)
    );

    always_comb begin
        acc_valid_d = acc_valid_q;
        acc_rs1_d   = acc_rs1_q;
        acc_imm_d   = acc_imm_q;
        acc_tag_d   = acc_tag_q;
        if (flush_i) begin
            acc_valid_d = 1'b0;
        end else if (accept) begin
            acc_valid_d = 1'b1;
            acc_rs1_d   = req_rs1_i;
            acc_imm_d   = req_imm_i;
            acc_tag_d   = head;
        end else if (acc_valid_q && acc_ready_i) begin
            acc_valid_d = 1'b0;
        end

        // Wait counter tracks only the oldest entry; it holds once that entry is done but not yet written back.
        tmo_cnt_d = tmo_cnt_q;
        if (flush_i || (count == '0) || commit) begin
            tmo_cnt_d = '0;
        end else if (!wb_valid_o && (tmo_cnt_q < TMO_W'(TIMEOUT_CYCLES))) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end

        timeout_d = flush_i ? 1'b0 : (timeout_q || (tmo_cnt_d == TMO_W'(TIMEOUT_CYCLES)));
        err_d     = flush_i ? 1'b0 : (err_q || (acc_res_valid_i && !res_hit));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_valid_q <= 1'b0;
            acc_rs1_q   <= '0;
            acc_imm_q   <= '0;
            acc_tag_q   <= '0;
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            acc_valid_q <= acc_valid_d;
            acc_rs1_q   <= acc_rs1_d;
            acc_imm_q   <= acc_imm_d;
            acc_tag_q   <= acc_tag_d;
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_dummy_accelerator_dispatcher.sv
// Bench for dummy_accelerator_dispatcher: directed scenarios plus random traffic against a transaction-level model.
module tb_dummy_accelerator_dispatcher;

    localparam int NT   = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_rs1_i;
    logic [10:0] req_imm_i;
    logic [4:0]  req_rd_i;
    logic        acc_valid_o;
    logic        acc_ready_i;
    logic [31:0] acc_rs1_o;
    logic [10:0] acc_imm_o;
    logic [1:0]  acc_tag_o;
    logic        acc_res_valid_i;
    logic        acc_res_ready_o;
    logic [31:0] acc_result_i;
    logic [1:0]  acc_tag_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [31:0] wb_result_o;
    logic [4:0]  wb_rd_o;
    logic        busy_o;
    logic        timeout_o;
    logic        err_o;

    dummy_accelerator_dispatcher #(
        .WIDTH(32), .IMM_WIDTH(11), .NUM_TAGS(NT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_rs1_i(req_rs1_i), .req_imm_i(req_imm_i), .req_rd_i(req_rd_i),
        .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
        .acc_rs1_o(acc_rs1_o), .acc_imm_o(acc_imm_o), .acc_tag_o(acc_tag_o),
        .acc_res_valid_i(acc_res_valid_i), .acc_res_ready_o(acc_res_ready_o),
        .acc_result_i(acc_result_i), .acc_tag_i(acc_tag_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_result_o(wb_result_o), .wb_rd_o(wb_rd_o),
        .busy_o(busy_o), .timeout_o(timeout_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct { int tag; logic [4:0] rd; logic [31:0] res; bit done; } ent_t;
    typedef struct { int tag; logic [31:0] res; int due; } pend_t;

    ent_t  mq[$];
    pend_t pq[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    next_tag;
    bit    m_iv;
    logic [31:0] m_rs1;
    logic [10:0] m_imm;
    int    m_tag;
    int    m_wait;
    bit    m_tmo, m_err;
    bit    force_res = 0;
    int    force_tag;
    logic [31:0] force_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete(); pq.delete();
        next_tag = 0; m_iv = 0; m_rs1 = '0; m_imm = '0; m_tag = 0;
        m_wait = 0; m_tmo = 0; m_err = 0;
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_acc_valid"}, acc_valid_o, 0);
        chk({pfx, "_wb_valid"}, wb_valid_o, 0);
        chk({pfx, "_busy"}, busy_o, 0);
        chk({pfx, "_timeout"}, timeout_o, 0);
        chk({pfx, "_err"}, err_o, 0);
        chk({pfx, "_res_ready"}, acc_res_ready_o, 1);
        chk({pfx, "_req_ready"}, req_ready_o, 1);
        chk({pfx, "_acc_rs1"}, acc_rs1_o, 0);
        chk({pfx, "_acc_imm"}, acc_imm_o, 0);
        chk({pfx, "_acc_tag"}, acc_tag_o, 0);
        chk({pfx, "_wb_result"}, wb_result_o, 0);
        chk({pfx, "_wb_rd"}, wb_rd_o, 0);
    endtask

    // Accelerator: result is rs1^imm, returned imm cycles after the issue handshake, one per cycle.
    task automatic drive_accel();
        int best;
        acc_res_valid_i = 1'b0; acc_tag_i = '0; acc_result_i = '0;
        if (acc_valid_o && acc_ready_i)
            pq.push_back('{int'(acc_tag_o), acc_rs1_o ^ {21'b0, acc_imm_o}, cyc + int'(acc_imm_o)});
        if (force_res) begin
            acc_res_valid_i = 1'b1; acc_tag_i = 2'(force_tag); acc_result_i = force_data;
            force_res = 0;
        end else begin
            best = -1;
            foreach (pq[i])
                if (pq[i].due <= cyc && (best < 0 || pq[i].due < pq[best].due)) best = i;
            if (best >= 0) begin
                acc_res_valid_i = 1'b1; acc_tag_i = 2'(pq[best].tag); acc_result_i = pq[best].res;
                pq.delete(best);
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_wbv;
        exp_wbv = (mq.size() > 0) && mq[0].done;
        chk("acc_valid", acc_valid_o, m_iv);
        if (m_iv) begin
            chk("acc_rs1", acc_rs1_o, m_rs1);
            chk("acc_imm", acc_imm_o, m_imm);
            chk("acc_tag", acc_tag_o, m_tag);
        end
        chk("wb_valid", wb_valid_o, exp_wbv);
        if (exp_wbv) begin
            chk("wb_result", wb_result_o, mq[0].res);
            chk("wb_rd", wb_rd_o, mq[0].rd);
        end
        chk("busy", busy_o, (mq.size() != 0) || m_iv);
        chk("req_ready", req_ready_o, (mq.size() < NT) && (!m_iv || acc_ready_i));
        chk("timeout", timeout_o, m_tmo);
        chk("err", err_o, m_err);
        chk("res_ready", acc_res_ready_o, 1);
    endtask

    task automatic model_update();
        bit rdy, commit, was_empty, head_done, found;
        rdy = (mq.size() < NT) && (!m_iv || acc_ready_i);
        if (flush_i) begin
            mq.delete(); pq.delete();
            next_tag = 0; m_iv = 0; m_wait = 0; m_tmo = 0; m_err = 0;
            return;
        end
        was_empty = (mq.size() == 0);
        head_done = !was_empty && mq[0].done;
        commit    = head_done && wb_ready_i;
        if (acc_res_valid_i) begin
            found = 0;
            foreach (mq[i])
                if (mq[i].tag == int'(acc_tag_i)) begin
                    mq[i].res = acc_result_i; mq[i].done = 1; found = 1;
                end
            if (!found) m_err = 1;
        end
        if (commit) void'(mq.pop_front());
        if (was_empty || commit) m_wait = 0;
        else if (!head_done && m_wait < TMO) m_wait++;
        if (m_wait == TMO) m_tmo = 1;
        if (req_valid_i && rdy) begin
            m_iv = 1; m_rs1 = req_rs1_i; m_imm = req_imm_i; m_tag = next_tag;
            mq.push_back('{next_tag, req_rd_i, 32'h0, 1'b0});
            next_tag = (next_tag + 1) % NT;
        end else if (m_iv && acc_ready_i) begin
            m_iv = 0;
        end
    endtask

    task automatic step();
        drive_accel();
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_req(input logic [31:0] rs1, input logic [10:0] imm, input logic [4:0] rd);
        req_valid_i = 1'b1; req_rs1_i = rs1; req_imm_i = imm; req_rd_i = rd;
    endtask

    task automatic do_flush();
        flush_i = 1'b1; step(); flush_i = 1'b0;
    endtask

    logic [4:0]  crd[$];
    int          ccy[$];
    logic [31:0] ra, rb;

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_rs1_i = '0; req_imm_i = '0;
        req_rd_i = '0; acc_ready_i = 1'b1; wb_ready_i = 1'b1;
        acc_res_valid_i = 1'b0; acc_result_i = '0; acc_tag_i = '0;
        model_reset();
        #12;
        reset_checks("rst");
        @(negedge clk);
        rst_ni = 1'b1;

        // Single zero-latency request
        set_req(32'h0000_00F0, 11'd0, 5'd5); step(); req_valid_i = 1'b0;
        chk("single_acc_valid_c1", acc_valid_o, 1);
        step();
        chk("single_wb_valid_c2", wb_valid_o, 1);
        chk("single_wb_result", wb_result_o, 32'hF0);
        chk("single_wb_rd", wb_rd_o, 5);
        step();

        // Out-of-order return, in-order commit
        do_flush();
        set_req($urandom, 11'd10, 5'd7); step();
        set_req($urandom, 11'd2, 5'd9); step(); req_valid_i = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (wb_valid_o && wb_ready_i) begin crd.push_back(wb_rd_o); ccy.push_back(cyc); end
            step();
        end
        chk("ooo_commit_count", crd.size(), 2);
        if (crd.size() == 2) begin
            chk("ooo_first_rd", crd[0], 7);
            chk("ooo_second_rd", crd[1], 9);
            chk("ooo_back_to_back", ccy[1] - ccy[0], 1);
        end

        // Full ROB and wrap-around
        do_flush();
        wb_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin set_req($urandom, 11'(i % 3), 5'(10 + i)); step(); end
        req_valid_i = 1'b0;
        chk("full_req_ready_low", req_ready_o, 0);
        repeat (6) step();
        chk("full_wb_valid", wb_valid_o, 1);
        wb_ready_i = 1'b1; step(); wb_ready_i = 1'b0;
        chk("full_req_ready_again", req_ready_o, 1);
        set_req($urandom, 11'd0, 5'd20); step(); req_valid_i = 1'b0;
        chk("wrap_tag0", acc_tag_o, 0);
        wb_ready_i = 1'b1;
        repeat (8) step();

        // Issue stall
        ra = $urandom; rb = $urandom;
        acc_ready_i = 1'b0;
        set_req(ra, 11'd3, 5'd21); step();
        set_req(rb, 11'd1, 5'd22);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_rs1", acc_rs1_o, ra);
            chk("stall_imm", acc_imm_o, 3);
            chk("stall_tag", acc_tag_o, m_tag);
            chk("stall_req_ready", req_ready_o, 0);
        end
        acc_ready_i = 1'b1; step(); req_valid_i = 1'b0;
        chk("stall_second_issued", acc_rs1_o, rb);
        repeat (10) step();

        // Timeout, error, flush
        do_flush();
        set_req($urandom, 11'd20, 5'd23); step(); req_valid_i = 1'b0;
        repeat (7) step();
        chk("timeout_not_yet", timeout_o, 0);
        step();
        chk("timeout_rise", timeout_o, 1);
        repeat (20) step();
        chk("timeout_sticky", timeout_o, 1);
        force_res = 1; force_tag = 2; force_data = $urandom; step();
        chk("err_set", err_o, 1);
        flush_i = 1'b1; set_req($urandom, 11'd0, 5'd24); step();
        flush_i = 1'b0; req_valid_i = 1'b0;
        chk("flush_timeout_clr", timeout_o, 0);
        chk("flush_err_clr", err_o, 0);
        chk("flush_busy_clr", busy_o, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            req_valid_i = 1'($urandom_range(0, 1));
            req_rs1_i   = $urandom;
            req_imm_i   = 11'($urandom_range(0, 5));
            req_rd_i    = 5'($urandom);
            acc_ready_i = ($urandom % 4) != 0;
            wb_ready_i  = ($urandom % 10) < 7;
            flush_i     = ($urandom % 64) == 0;
            if (($urandom % 32) == 0) begin
                int t;
                bit hit;
                t = int'($urandom % NT); hit = 0;
                foreach (mq[k]) if (mq[k].tag == t) hit = 1;
                if (!hit) begin force_res = 1; force_tag = t; force_data = $urandom; end
            end
            step();
        end
        flush_i = 1'b0; req_valid_i = 1'b0; acc_ready_i = 1'b1; wb_ready_i = 1'b1;
        repeat (20) step();

        // Asynchronous reset mid-transaction
        wb_ready_i = 1'b0;
        set_req($urandom, 11'd0, 5'd25); step();
        set_req($urandom, 11'd1, 5'd26); step(); req_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1 reset_checks("midrst");
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1; wb_ready_i = 1'b1;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
